// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and PC-stage state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // ECALL/EBREAK share funct3 000 under the SYSTEM opcode
  localparam logic [2:0] F3_PRIV = 3'b000;

  typedef enum logic [1:0] {RUN, HALT, TRAP} pc_state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational B-type condition evaluation from the two register operands.
module branch_compare
  import riscv_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rs1_data,
  input  logic [Width-1:0] rs2_data,
  input  logic [2:0]       funct3,
  output logic             take
);

  // Decode funct3 into the comparison; reserved encodings never take
  always_comb begin
    take = 1'b0;
    case (funct3)
      F3_BEQ:  take = (rs1_data == rs2_data);
      F3_BNE:  take = (rs1_data != rs2_data);
      F3_BLT:  take = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  take = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: take = (rs1_data <  rs2_data);
      F3_BGEU: take = (rs1_data >= rs2_data);
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter / next-PC stage: branch and jump resolution, halt on
// ECALL/EBREAK, trap on misaligned taken targets.
// Optional feature: define PC_PERF_COUNTERS_EN to add retired/taken counters.
module pc_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] instr,
  input  logic [Width-1:0] imm,
  input  logic [Width-1:0] rs1_data,
  input  logic [Width-1:0] rs2_data,
  input  logic             stall,
  output logic [Width-1:0] pc,
  output logic [Width-1:0] pc_plus4,
  output logic             branch_taken,
  output logic             misalign_trap,
`ifdef PC_PERF_COUNTERS_EN
  output logic [31:0]      cnt_retired,
  output logic [31:0]      cnt_taken,
`endif
  output logic             halted
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             cmp_take;
  logic             redirect;
  logic             active;
  logic             misalign;
  logic             is_halt;
  logic [Width-1:0] target;
  logic [Width-1:0] pc_q, pc_d;
  pc_state_t        state_q, state_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Only opcode and funct3 are decoded here
  logic unused_instr;
  assign unused_instr = ^{instr[Width-1:15], instr[11:7]};

  branch_compare #(
    .Width (Width)
  ) u_branch_compare (
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .funct3   (funct3),
    .take     (cmp_take)
  );

  // Select redirect condition and target; imm arrives halved for B/J-type
  always_comb begin
    redirect = 1'b0;
    target   = pc_q + (imm << 1);
    case (opcode)
      OP_BRANCH: redirect = cmp_take;
      OP_JAL:    redirect = 1'b1;
      OP_JALR: begin
        redirect = 1'b1;
        target   = (rs1_data + imm) & ~Width'(1);
      end
      default:   redirect = 1'b0;
    endcase
  end

  assign active       = (state_q == RUN) && !stall;
  assign branch_taken = redirect && active;
  // A not-taken branch never traps, whatever its target alignment
  assign misalign     = branch_taken && (target[1:0] != 2'b00);
  assign is_halt      = (opcode == OP_SYSTEM) && (funct3 == F3_PRIV);
  assign pc_plus4     = pc_q + Width'(4);

  // Next PC and state; stall and HALT/TRAP hold everything
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (active) begin
      if (misalign) begin
        state_d = TRAP;
      end else if (is_halt) begin
        state_d = HALT;
      end else if (branch_taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // PC and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc            = pc_q;
  assign misalign_trap = (state_q == TRAP);
  assign halted        = (state_q == HALT);

`ifdef PC_PERF_COUNTERS_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;

  // Saturating counters; an instruction that traps neither retires nor counts as taken
  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (active && !misalign) begin
      if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
      if (branch_taken && (opcode == OP_BRANCH) && (taken_q != 32'hFFFF_FFFF)) begin
        taken_d = taken_q + 32'd1;
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign cnt_retired = retired_q;
  assign cnt_taken   = taken_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the expected outputs of each
// cycle, a negedge monitor pops and compares.
module tb_pc_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] JALR  = 32'h0000_0067;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] BNE   = 32'h0000_1063;
  localparam logic [31:0] BF010 = 32'h0000_2063;
  localparam logic [31:0] BLT   = 32'h0000_4063;
  localparam logic [31:0] BGE   = 32'h0000_5063;
  localparam logic [31:0] BLTU  = 32'h0000_6063;
  localparam logic [31:0] BGEU  = 32'h0000_7063;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, imm, rs1, rs2;
  logic        stall;
  logic [31:0] pc, pc_plus4;
  logic        branch_taken, misalign_trap, halted;
`ifdef PC_PERF_COUNTERS_EN
  logic [31:0] cnt_retired, cnt_taken;
`endif

  pc_unit #(
    .Width    (32),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .imm           (imm),
    .rs1_data      (rs1),
    .rs2_data      (rs2),
    .stall         (stall),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .misalign_trap (misalign_trap),
`ifdef PC_PERF_COUNTERS_EN
    .cnt_retired   (cnt_retired),
    .cnt_taken     (cnt_taken),
`endif
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        bt;
    logic        trap;
    logic        halt;
    logic [31:0] ret;
    logic [31:0] tak;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_tak = 32'd0;

  // Apply one cycle of stimulus, queue what the DUT must show, then advance
  task automatic step(input logic [31:0] i, input logic [31:0] im, input logic [31:0] r1,
                      input logic [31:0] r2, input logic st, input logic [31:0] epc,
                      input logic ebt, input logic etrap, input logic ehalt,
                      input logic mis, input string nm);
    exp_t e;
    logic [6:0] op;
    instr = i; imm = im; rs1 = r1; rs2 = r2; stall = st;
    e.pc = epc; e.pc4 = epc + 32'd4; e.bt = ebt; e.trap = etrap; e.halt = ehalt;
    e.ret = m_ret; e.tak = m_tak;
    exp_q.push_back(e);
    name_q.push_back(nm);
    op = i[6:0];
    if (reset) begin
      m_ret = 32'd0; m_tak = 32'd0;
    end else if (!st && !etrap && !ehalt && !mis) begin
      m_ret = m_ret + 32'd1;
      if (ebt && op == 7'b1100011) m_tak = m_tak + 32'd1;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (pc !== e.pc || pc_plus4 !== e.pc4 || branch_taken !== e.bt ||
          misalign_trap !== e.trap || halted !== e.halt) begin
        failures++;
        $display("FAIL %s: got pc=%h pc4=%h bt=%b trap=%b halt=%b want pc=%h pc4=%h bt=%b trap=%b halt=%b",
                 n, pc, pc_plus4, branch_taken, misalign_trap, halted,
                 e.pc, e.pc4, e.bt, e.trap, e.halt);
      end
`ifdef PC_PERF_COUNTERS_EN
      checks++;
      if (cnt_retired !== e.ret || cnt_taken !== e.tak) begin
        failures++;
        $display("FAIL %s_cnt: got ret=%0d tak=%0d want ret=%0d tak=%0d",
                 n, cnt_retired, cnt_taken, e.ret, e.tak);
      end
`endif
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; instr = NOP; imm = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   instr  imm           rs1           rs2    st  pc            bt trp hlt mis
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0100, 0, 0, 0, 0, "reset_pc");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0104, 0, 0, 0, 0, "nop1");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0108, 0, 0, 0, 0, "nop2");
    step(JAL,   32'h7A,       32'd0,        32'd0, 0, 32'h0000_010C, 1, 0, 0, 0, "jal_fwd");
    step(BEQ,   32'd8,        32'd5,        32'd6, 0, 32'h0000_0200, 0, 0, 0, 0, "beq_nt");
    step(JAL,   32'hFFFF_FFFE, 32'd0,       32'd0, 0, 32'h0000_0204, 1, 0, 0, 0, "jal_back");
    step(BEQ,   32'd8,        32'd5,        32'd5, 0, 32'h0000_0200, 1, 0, 0, 0, "beq_t");
    step(BLT,   32'd4,        32'hFFFF_FFFF, 32'd1, 0, 32'h0000_0210, 1, 0, 0, 0, "blt_t");
    step(BLTU,  32'd4,        32'hFFFF_FFFF, 32'd1, 0, 32'h0000_0218, 0, 0, 0, 0, "bltu_nt");
    step(BNE,   32'd4,        32'd3,        32'd3, 0, 32'h0000_021C, 0, 0, 0, 0, "bne_nt");
    step(BGEU,  32'd2,        32'hFFFF_FFFF, 32'd1, 0, 32'h0000_0220, 1, 0, 0, 0, "bgeu_t");
    step(BGE,   32'd2,        32'hFFFF_FFFF, 32'd1, 0, 32'h0000_0224, 0, 0, 0, 0, "bge_nt");
    step(BF010, 32'd2,        32'd7,        32'd7, 0, 32'h0000_0228, 0, 0, 0, 0, "f3_010");
    step(BNE,   32'd1,        32'd9,        32'd9, 0, 32'h0000_022C, 0, 0, 0, 0, "nt_misal");
    step(JAL,   32'h40,       32'd0,        32'd0, 1, 32'h0000_0230, 0, 0, 0, 0, "stall_jal");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0230, 0, 0, 0, 0, "post_stall");
    step(JALR,  32'd4,        32'hFFFF_FFF8, 32'd0, 0, 32'h0000_0234, 1, 0, 0, 0, "jalr_top");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, "wrap");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0000, 0, 0, 0, 0, "wrapped");
    step(JAL,   32'h1E,       32'd0,        32'd0, 0, 32'h0000_0004, 1, 0, 0, 0, "jal_40");
    step(ECALL, 32'd0,        32'd0,        32'd0, 0, 32'h0000_0040, 0, 0, 0, 0, "ecall");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0040, 0, 0, 1, 0, "halted");
    step(JAL,   32'h40,       32'd0,        32'd0, 0, 32'h0000_0040, 0, 0, 1, 0, "halt_jal");
    reset = 1'b1;
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0040, 0, 0, 1, 0, "halt_rst");
    reset = 1'b0;
    step(ECALL, 32'd0,        32'd0,        32'd0, 1, 32'h0000_0100, 0, 0, 0, 0, "stall_ecall");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0100, 0, 0, 0, 0, "after_rst");
    step(JALR,  32'd2,        32'h0000_0301, 32'd0, 0, 32'h0000_0104, 1, 0, 0, 1, "jalr_misal");
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0104, 0, 1, 0, 0, "trapped");
    step(JAL,   32'h40,       32'd0,        32'd0, 0, 32'h0000_0104, 0, 1, 0, 0, "trap_jal");
    reset = 1'b1;
    step(NOP,   32'd0,        32'd0,        32'd0, 1, 32'h0000_0104, 0, 1, 0, 0, "trap_rst");
    reset = 1'b0;
    step(NOP,   32'd0,        32'd0,        32'd0, 0, 32'h0000_0100, 0, 0, 0, 0, "trap_clr");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and next-PC stage of the single-cycle three-bus RV32I core. Holds the architectural PC, resolves branches and jumps from the sign-extended immediate produced by the immediate generator and the register-file read data, and drives the instruction-memory fetch address. Halts on ECALL/EBREAK and traps on misaligned control-flow targets.

## Interface
- Width, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high
- instr  input  Width  current instruction; uses [6:0] opcode and [14:12] funct3
- imm  input  Width  sign-extended immediate from the immediate generator; for B- and J-type this is the offset divided by 2 (bit 0 not included)
- rs1_data  input  Width  register-file read port 1
- rs2_data  input  Width  register-file read port 2
- stall  input  1  hold PC and state this cycle
- pc  output  Width  registered PC, fetch address
- pc_plus4  output  Width  pc + 4, link value for JAL/JALR write-back
- branch_taken  output  1  current instruction redirects the PC
- misalign_trap  output  1  unit is in TRAP state
- halted  output  1  unit is in HALT state

## Operation
- States: RUN, HALT, TRAP. Reset -> RUN. HALT and TRAP exit only via reset.
- Target computation, all modulo 2^Width:
  - B-type (1100011): target = pc + (imm << 1), taken per funct3: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; 010/011 never taken.
  - JAL (1101111): target = pc + (imm << 1), always taken.
  - JALR (1100111): target = (rs1_data + imm) with bit 0 cleared, always taken.
  - All other opcodes: next = pc + 4.
- branch_taken = redirect condition AND state==RUN AND !stall.
- Misalign: taken redirect with target[1:0] != 0 -> PC not updated, next state TRAP. Not-taken branch to a misaligned target does not trap.
- SYSTEM (1110011) with funct3 000 (ECALL/EBREAK) in RUN, no stall -> PC holds, next state HALT.
- stall=1: PC, state and counters hold; branch_taken forced 0. Stall overrides halt and trap detection in the same cycle.
- In HALT/TRAP: PC holds, branch_taken 0.

## Timing
- pc, state: registered; update on rising clk when !stall.
- pc_plus4, branch_taken: combinational from pc, instr, imm, rs1/rs2 in the same cycle.
- Redirect latency: target visible on pc one cycle after the instruction is presented.
- misalign_trap, halted: decoded from registered state; assert the cycle after the causing instruction.
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, branch_taken=0, misalign_trap=0, halted=0, counters 0.
- Reset asserted mid-stall or in HALT/TRAP: reset wins, RUN next cycle.

## Configuration
- PC_PERF_COUNTERS_EN defined: adds outputs cnt_retired (32) and cnt_taken (32). cnt_retired +1 per RUN cycle with !stall that does not enter TRAP (halting instruction counts). cnt_taken +1 per taken B-type only. Both saturate at 32'hFFFF_FFFF, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package riscv_pkg: opcode constants (OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM), branch funct3 constants, pc_state_t enum {RUN, HALT, TRAP}.
- One sub-module: branch_compare (rs1_data, rs2_data, funct3 -> take), purely combinational.

## Test plan
- Reset with RESET_PC=32'h100, stall=0, NOPs (0x00000013) -> pc 0x100, 0x104, 0x108; halted=0.
- pc=0x200, BEQ with imm=8 (offset 16), rs1=rs2=5 -> branch_taken=1, next pc 0x210; rs2=6 -> pc 0x204.
- BLT rs1=0xFFFF_FFFF, rs2=1 -> taken; BLTU same operands -> not taken.
- JALR rs1=0x301, imm=2 -> pc 0x302 misaligned -> pc holds, misalign_trap=1 next cycle, held until reset.
- pc=0xFFFF_FFFC, NOP -> pc wraps to 0x0000_0000; stall=1 during JAL -> pc holds, branch_taken=0.
- ECALL at pc 0x40 -> halted=1, pc stays 0x40; with PC_PERF_COUNTERS_EN cnt_retired includes the ECALL and then freezes.
